fpu_seq_divider: RTL and testbench



---
 rtl/fpu_div_pkg.sv | 15 +
 rtl/fpu_seq_divider_fsm.sv | 49 ++++
 rtl/fpu_seq_divider.sv | 124 ++++++++++++
 tb/tb_fpu_seq_divider.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared types and helpers for the sequential FPU mantissa divider.
package fpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } fpuSeqDivState_t;

  // Quotient width: integer bits plus the extra fractional bits.
  function automatic int calcQw(input int width, input int fracw);
    return width + fracw;
  endfunction

endpackage

// File: rtl/fpu_seq_divider_fsm.sv
// Control FSM for fpu_seq_divider: handshake outputs, load/step enables and
// the next-state decode. The state register itself lives in the top module.
module fpu_seq_divider_fsm
  import fpu_div_pkg::*;
(
  input  fpuSeqDivState_t state,
  input  logic            in_valid,
  input  logic            out_ready,
  input  logic            counterDone,
  input  logic            fastQualify,
  output logic            in_ready,
  output logic            out_valid,
  output logic            loadEn,
  output logic            stepEn,
  output fpuSeqDivState_t nextState
);

  // Decode handshake flags, datapath enables and the next state from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    loadEn    = 1'b0;
    stepEn    = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          loadEn    = 1'b1;
          nextState = fastQualify ? DONE : COMP;
        end
      end
      COMP: begin
        stepEn = 1'b1;
        if (counterDone) begin
          nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: rtl/fpu_seq_divider.sv
// Handshaked unsigned restoring divider producing a quotient with FRACW
// fractional bits, a remainder, a sticky bit and a divide-by-zero flag.
// Optional macro FPU_DIV_FAST_PATH_EN: zero dividend or zero divisor skips
// the iteration and goes straight to DONE with the same results.
module fpu_seq_divider
  import fpu_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRACW = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       dividend,
  input  logic [WIDTH-1:0]       divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+FRACW-1:0] quotient,
  output logic [WIDTH-1:0]       remainder,
  output logic                   sticky,
  output logic                   div_zero
);

  localparam int QW = calcQw(WIDTH, FRACW);
  localparam int CW = $clog2(QW + 1);

  fpuSeqDivState_t state;
  fpuSeqDivState_t nextState;

  logic [QW-1:0]    paddedIn;
  logic [QW-1:0]    shiftReg;
  logic [QW-1:0]    quotReg;
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH-1:0] remReg;
  logic             stickyReg;
  logic             divZeroReg;
  logic [CW-1:0]    counter;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] stepRem;

  logic loadEn;
  logic stepEn;
  logic counterDone;
  logic fastQualify;

  assign paddedIn    = {dividend, {FRACW{1'b0}}};
  assign counterDone = (counter == CW'(1));

`ifdef FPU_DIV_FAST_PATH_EN
  assign fastQualify = (dividend == '0) || (divisor == '0);
`else
  assign fastQualify = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit and try to subtract;
  // the borrow is taken one bit wider so a zero divisor never borrows.
  always_comb begin
    shifted = {remReg, shiftReg[QW-1]};
    {borrow, trial} = {1'b0, shifted} - {2'b0, divisorReg};
    stepRem = WIDTH'(borrow ? shifted : trial);
  end

  fpu_seq_divider_fsm uFsm (
    .state       (state),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .counterDone (counterDone),
    .fastQualify (fastQualify),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .loadEn      (loadEn),
    .stepEn      (stepEn),
    .nextState   (nextState)
  );

  // State register and datapath: load operands on accept, iterate in COMP,
  // and otherwise hold so results stay stable while DONE waits for out_ready.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      shiftReg   <= '0;
      quotReg    <= '0;
      divisorReg <= '0;
      remReg     <= '0;
      stickyReg  <= 1'b0;
      divZeroReg <= 1'b0;
      counter    <= '0;
    end else begin
      state <= nextState;
      if (loadEn) begin
        shiftReg   <= paddedIn;
        divisorReg <= divisor;
        divZeroReg <= (divisor == '0);
        counter    <= CW'(QW);
        remReg     <= '0;
        quotReg    <= '0;
        stickyReg  <= 1'b0;
`ifdef FPU_DIV_FAST_PATH_EN
        if (divisor == '0) begin
          quotReg   <= '1;
          remReg    <= paddedIn[WIDTH-1:0];
          stickyReg <= (paddedIn[WIDTH-1:0] != '0);
        end
`endif
      end else if (stepEn) begin
        shiftReg  <= {shiftReg[QW-2:0], 1'b0};
        quotReg   <= {quotReg[QW-2:0], ~borrow};
        remReg    <= stepRem;
        stickyReg <= (stepRem != '0);
        counter   <= counter - CW'(1);
      end
    end
  end

  assign quotient  = quotReg;
  assign remainder = remReg;
  assign sticky    = stickyReg;
  assign div_zero  = divZeroReg;

endmodule

// File: tb/tb_fpu_seq_divider.sv
// Self-checking bench for fpu_seq_divider (WIDTH=16, FRACW=10): expected
// results are computed from the arithmetic definition and queued when a
// request is driven, then popped and compared when out_valid is seen.
module tb_fpu_seq_divider;

  localparam int WIDTH = 16;
  localparam int FRACW = 10;
  localparam int QW    = WIDTH + FRACW;

  typedef struct {
    logic [QW-1:0]    q;
    logic [WIDTH-1:0] r;
    logic             s;
    logic             dz;
  } expect_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [QW-1:0]    quotient;
  logic [WIDTH-1:0] remainder;
  logic             sticky;
  logic             div_zero;

  expect_t sb[$];
  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  int acceptCycle = 0;

  fpu_seq_divider #(.WIDTH(WIDTH), .FRACW(FRACW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .sticky    (sticky),
    .div_zero  (div_zero)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Edge counter used to measure latency and request spacing.
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Hard stop in case something above ever stops advancing.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    expect_t e;
    logic [QW-1:0] pad;
    pad = {dvd, {FRACW{1'b0}}};
    if (dvs == '0) begin
      e.q = '1;
      e.r = pad[WIDTH-1:0];
    end else begin
      e.q = pad / QW'(dvs);
      e.r = WIDTH'(pad % QW'(dvs));
    end
    e.s  = (e.r != '0);
    e.dz = (dvs == '0);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    int waited;
    pushExpected(dvd, dvs);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    checkValue("accept_ready", in_ready, 1);
    tick();
    acceptCycle = cycleCount;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int expLat);
    int waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    checkValue({tag, "_valid"}, out_valid, 1);
    if (expLat >= 0) checkValue({tag, "_latency"}, cycleCount - acceptCycle, expLat);
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    checkValue({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkValue({tag, "_quotient"}, quotient, e.q);
      checkValue({tag, "_remainder"}, remainder, e.r);
      checkValue({tag, "_sticky"}, sticky, e.s);
      checkValue({tag, "_div_zero"}, div_zero, e.dz);
    end
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkValue({tag, "_valid_drop"}, out_valid, 0);
    checkValue({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_in_ready"}, in_ready, 1);
    checkValue({tag, "_out_valid"}, out_valid, 0);
    checkValue({tag, "_quotient"}, quotient, 0);
    checkValue({tag, "_remainder"}, remainder, 0);
    checkValue({tag, "_sticky"}, sticky, 0);
    checkValue({tag, "_div_zero"}, div_zero, 0);
  endtask

  // Directed sequence: reset, basic divides, divide-by-zero, backpressure,
  // back-to-back throughput, reset mid-iteration, then a few random divides.
  initial begin
    int accept0;
    int accept1;
    int waited;
    logic [QW-1:0] heldQ;
    logic [WIDTH-1:0] heldR;
    logic [WIDTH-1:0] rDvd;
    logic [WIDTH-1:0] rDvs;

    reset_n = 1'b0;
    tick();
    tick();
    checkResetState("reset");
    reset_n = 1'b1;
    tick();

    applyStimulus(16'h0003, 16'h0002);
    waitResult("div3by2", QW);
    checkOutput("div3by2");
    releaseResult("div3by2");

    applyStimulus(16'h0001, 16'h0003);
    waitResult("div1by3", QW);
    checkOutput("div1by3");
    releaseResult("div1by3");

    applyStimulus(16'h1234, 16'h0000);
`ifdef FPU_DIV_FAST_PATH_EN
    waitResult("divzero", -1);
`else
    waitResult("divzero", QW);
`endif
    checkOutput("divzero");
    releaseResult("divzero");

    // Backpressure: hold out_ready low for 5 cycles with a stray request.
    applyStimulus(16'h0007, 16'h0005);
    waitResult("bp", QW);
    heldQ = quotient;
    heldR = remainder;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        dividend = 16'h0042;
        divisor  = 16'h0001;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      checkValue("bp_in_ready", in_ready, 0);
      checkValue("bp_out_valid", out_valid, 1);
      checkValue("bp_quot_stable", quotient, heldQ);
      checkValue("bp_rem_stable", remainder, heldR);
    end
    in_valid = 1'b0;
    checkOutput("bp");
    releaseResult("bp");
    for (int i = 0; i < QW + 4; i++) tick();
    checkValue("bp_stray_ignored", out_valid, 0);

    // Back-to-back with out_ready held high; second request held waiting.
    out_ready = 1'b1;
    pushExpected(16'hFFFF, 16'h0001);
    pushExpected(16'h8000, 16'hFFFF);
    dividend = 16'hFFFF;
    divisor  = 16'h0001;
    in_valid = 1'b1;
    tick();
    accept0 = cycleCount;
    acceptCycle = accept0;
    dividend = 16'h8000;
    divisor  = 16'hFFFF;
    waitResult("b2b_first", QW);
    checkOutput("b2b_first");
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    tick();
    accept1 = cycleCount;
    acceptCycle = accept1;
    in_valid = 1'b0;
    checkValue("b2b_spacing", accept1 - accept0, QW + 2);
    waitResult("b2b_second", QW);
    checkOutput("b2b_second");
    tick();
    out_ready = 1'b0;
    checkValue("b2b_drained", out_valid, 0);

    // Reset in the middle of the iteration discards the request.
    applyStimulus(16'h00FF, 16'h0003);
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkResetState("midreset");
    void'(sb.pop_front());
    applyStimulus(16'h0100, 16'h0007);
    waitResult("after_reset", QW);
    checkOutput("after_reset");
    releaseResult("after_reset");

    for (int i = 0; i < 4; i++) begin
      rDvd = WIDTH'($urandom);
      rDvs = WIDTH'($urandom_range(1, 65535));
      applyStimulus(rDvd, rDvs);
      waitResult("random", QW);
      checkOutput("random");
      releaseResult("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
